stream_fifo_sync: RTL and testbench

- Single-clock, first-word-fall-through FIFO with valid/ready streaming ports on both sides.
- Buffers fixed-width sample words (48-bit stereo sample pairs) between a producer and a consumer that share the master clock, for example loopback of samples from an ADC slot model into a DAC slot model.
- Reports the current occupancy for monitoring.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_regfile.sv | 36 +++
 rtl/stream_fifo_sync.sv | 89 ++++++++
 tb/tb_stream_fifo_sync.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock streaming FIFO.
//   FIFO_NB      default data word width (48-bit stereo sample pair)
//   FIFO_M       default log2 of FIFO depth (depth = 4 words)
//   count_width  width of an occupancy counter able to hold 0..2**m
package fifo_pkg;

  localparam int FIFO_NB = 48;
  localparam int FIFO_M  = 2;

  // Occupancy runs 0..2**m inclusive, so it needs one bit more than a pointer.
  function automatic int count_width(input int m);
    return m + 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the streaming FIFO: Nb x 2**M words.
// Contents are deliberately not reset; validity is tracked by the occupancy
// count in the FIFO top.
// Ports:
//   clk    master clock, write on rising edge
//   we     write enable
//   waddr  write address (M bits)
//   wdata  write data (Nb bits)
//   raddr  read address (M bits)
//   rdata  asynchronous read data, mem[raddr]
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int Nb = FIFO_NB,
  parameter int M  = FIFO_M
) (
  input  logic          clk,
  input  logic          we,
  input  logic [M-1:0]  waddr,
  input  logic [Nb-1:0] wdata,
  input  logic [M-1:0]  raddr,
  output logic [Nb-1:0] rdata
);

  logic [Nb-1:0] mem [2**M];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read gives first-word-fall-through behaviour at the top.
  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo_sync.sv
// Single-clock first-word-fall-through FIFO with valid/ready streaming ports.
// Buffers sample words between a producer and a consumer on the same clock and
// reports its occupancy.
//
// Handshake: a word moves on a rising edge only when valid and ready are both
// high on that side. in_ready and out_valid depend only on the registered count
// (and reset_n), never on the opposite side's valid/ready, so there is no
// combinational path from in_valid to in_ready or from out_ready to out_valid.
// An empty FIFO is never bypassed: a pushed word appears one edge later.
//
// Ports:
//   clk        master clock, rising edge
//   reset_n    asynchronous active-low reset (clears pointers and count)
//   in_data    write-side data word
//   in_valid   producer offers in_data
//   in_ready   FIFO can accept a word (low during reset and when full)
//   out_data   head-of-queue word (0 during reset)
//   out_valid  out_data holds a valid word
//   out_ready  consumer takes out_data
//   count      number of stored words, 0..2**M
module stream_fifo_sync
  import fifo_pkg::*;
#(
  parameter int Nb = FIFO_NB,
  parameter int M  = FIFO_M
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [Nb-1:0]             in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [Nb-1:0]             out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [count_width(M)-1:0] count
);

  localparam int            CW   = count_width(M);
  localparam logic [CW-1:0] FULL = CW'(2**M);

  logic [M-1:0]  wr_ptr;
  logic [M-1:0]  rd_ptr;
  logic [CW-1:0] count_q;
  logic [Nb-1:0] rdata;
  logic          push;
  logic          pop;

  assign in_ready  = reset_n && (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  fifo_regfile #(
    .Nb (Nb),
    .M  (M)
  ) u_regfile (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign out_data = reset_n ? rdata : '0;
  assign count    = count_q;

endmodule

// File: tb/tb_stream_fifo_sync.sv
// Self-checking bench for stream_fifo_sync: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_stream_fifo_sync;

  localparam int NB    = 48;
  localparam int M     = 2;
  localparam int DEPTH = 2**M;

  // Clock / reset
  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [M:0]    count;

  always #5 clk = ~clk;

  stream_fifo_sync #(
    .Nb (NB),
    .M  (M)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  // Scoreboard: the reference model is simply the queue of stored words.
  logic [NB-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all DUT outputs against the model (called away from the rising edge).
  task automatic check_outputs(input string tag);
    check({tag, ".count"},     64'(count),     64'(exp_q.size()));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
    check({tag, ".in_ready"},  64'(in_ready),  64'(exp_q.size() < DEPTH));
    if (exp_q.size() != 0) begin
      check({tag, ".out_data"}, 64'(out_data), 64'(exp_q[0]));
    end
  endtask

  // Driver: apply current inputs across one rising edge, update the model,
  // then check on the falling edge.
  task automatic step(input string tag);
    bit do_push;
    bit do_pop;
    do_push = in_valid && (exp_q.size() < DEPTH);
    do_pop  = out_ready && (exp_q.size() != 0);
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(in_data);
    @(negedge clk);
    check_outputs(tag);
  endtask

  logic [NB-1:0] held;

  initial begin
    reset_n   = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    check("rst.count",     64'(count),     64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd0);
    check("rst.out_data",  64'(out_data),  64'd0);
    reset_n = 1'b1;
    step("post_rst");
    check("post_rst.in_ready1", 64'(in_ready), 64'd1);
    for (int i = 0; i < 10; i++) step("idle");

    // Fill to full
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = NB'(i);
      step("fill");
      check("fill.count_step", 64'(count), 64'(i));
    end
    check("full.in_ready", 64'(in_ready), 64'd0);
    in_data = 48'hDEAD;
    for (int i = 0; i < 3; i++) begin
      step("overflow");
      check("overflow.count4", 64'(count), 64'd4);
    end

    // Drain in order
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain.head", 64'(out_data), 64'(i));
      step("drain");
      check("drain.count_step", 64'(count), 64'(4 - i));
    end
    check("drain.empty_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 2; i++) step("underflow");

    // Concurrent streaming with wrap
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = NB'(i);
      if (i > 0) check("stream.head", 64'(out_data), 64'(i - 1));
      step("stream");
      check("stream.count1", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    check("stream.last", 64'(out_data), 64'd19);
    step("stream_tail");
    check("stream.empty", 64'(count), 64'd0);

    // Backpressure stability
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 48'hA0A0_0000_0001; step("bp_fill");
    in_data   = 48'hA0A0_0000_0002; step("bp_fill");
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp.head0", 64'(out_data), 64'hA0A0_0000_0001);
    step("bp_pop");
    out_ready = 1'b0;
    held = out_data;
    check("bp.head1", 64'(held), 64'hA0A0_0000_0002);
    step("bp_hold");
    check("bp.stable1", 64'(out_data), 64'(held));
    step("bp_hold");
    check("bp.stable2", 64'(out_data), 64'(held));
    out_ready = 1'b1;
    step("bp_pop");
    check("bp.empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Reset mid-operation
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 48'h0BAD_0000_0000 | NB'(i);
      step("pre_rst_fill");
    end
    in_valid = 1'b0;
    check("pre_rst.count3", 64'(count), 64'd3);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst.count",     64'(count),     64'd0);
    check("mid_rst.out_valid", 64'(out_valid), 64'd0);
    check("mid_rst.in_ready",  64'(in_ready),  64'd0);
    exp_q.delete();
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_outputs("post_mid_rst");
    in_valid = 1'b1;
    in_data  = 48'h1234_5678_9ABC;
    step("after_rst_push");
    in_valid = 1'b0;
    check("after_rst.head", 64'(out_data), 64'h1234_5678_9ABC);
    out_ready = 1'b1;
    step("after_rst_pop");
    check("after_rst.empty", 64'(out_valid), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      in_data   = {16'($urandom), 32'($urandom)};
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
